// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational ALU between two requesters,
// with registered ALU drive and a registered response handshake.
module alu_share_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_src1,
    input  logic [2*DATA_W-1:0] req_src2,
    input  logic [7:0]          req_ctrl,
    output logic [DATA_W-1:0]   alu_src1,
    output logic [DATA_W-1:0]   alu_src2,
    output logic                alu_invert_a,
    output logic                alu_invert_b,
    output logic [1:0]          alu_operation,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_zero,
    input  logic                alu_overflow,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_id,
    output logic [DATA_W-1:0]   resp_result,
    output logic                resp_zero,
    output logic                resp_overflow
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    logic        rr_ptr;
    logic        id;
    logic        grant_id;
    logic        any_valid;
    logic        accept;
    logic [3:0]  grant_ctrl;

    // Prefer the pointed-to requester, fall back to the other one.
    assign grant_id   = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
    assign any_valid  = |req_valid;
    assign accept     = (state == IDLE) && any_valid && !rst;
    assign req_ready  = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign grant_ctrl = grant_id ? req_ctrl[7:4] : req_ctrl[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= 1'b0;
            id            <= 1'b0;
            alu_src1      <= '0;
            alu_src2      <= '0;
            alu_invert_a  <= 1'b0;
            alu_invert_b  <= 1'b0;
            alu_operation <= 2'b00;
            resp_valid    <= 1'b0;
            resp_id       <= 1'b0;
            resp_result   <= '0;
            resp_zero     <= 1'b0;
            resp_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    alu_src1      <= grant_id ? req_src1[2*DATA_W-1:DATA_W] : req_src1[DATA_W-1:0];
                    alu_src2      <= grant_id ? req_src2[2*DATA_W-1:DATA_W] : req_src2[DATA_W-1:0];
                    alu_invert_a  <= grant_ctrl[3];
                    alu_invert_b  <= grant_ctrl[2];
                    alu_operation <= grant_ctrl[1:0];
                    id            <= grant_id;
                    rr_ptr        <= ~grant_id;
                    state         <= EXEC;
                end
                EXEC: begin
                    resp_result   <= alu_result;
                    resp_zero     <= alu_zero;
                    resp_overflow <= alu_overflow;
                    resp_id       <= id;
                    resp_valid    <= 1'b1;
                    // ALU inputs go quiet outside the single execute cycle.
                    alu_src1      <= '0;
                    alu_src2      <= '0;
                    alu_invert_a  <= 1'b0;
                    alu_invert_b  <= 1'b0;
                    alu_operation <= 2'b00;
                    state         <= RESP;
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: table vectors, hand-written corner sequences and random ops
// checked against a behavioural ALU and round-robin model.
module tb_alu_share_arbiter;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_src1, req_src2;
    logic [7:0]     req_ctrl;
    logic [W-1:0]   alu_src1, alu_src2, alu_result;
    logic           alu_invert_a, alu_invert_b, alu_zero, alu_overflow;
    logic [1:0]     alu_operation;
    logic           resp_valid, resp_ready, resp_id, resp_zero, resp_overflow;
    logic [W-1:0]   resp_result;

    int vectors = 0;
    int miscompares = 0;
    logic pref = 1'b0;

    alu_share_arbiter #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_src1(req_src1), .req_src2(req_src2), .req_ctrl(req_ctrl),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_invert_a(alu_invert_a),
        .alu_invert_b(alu_invert_b), .alu_operation(alu_operation),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_zero(resp_zero), .resp_overflow(resp_overflow)
    );

    always #5 clk = ~clk;

    // Reference ALU: ctrl = {invertA, invertB, op}; op 00 and, 01 or, 10 add (carry-in = invertB), 11 slt.
    function automatic logic [W+1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
        logic [W-1:0] x, y, s, r;
        logic v;
        x = c[3] ? ~a : a;
        y = c[2] ? ~b : b;
        s = x + y + {31'd0, c[2]};
        v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
        case (c[1:0])
            2'b00: r = x & y;
            2'b01: r = x | y;
            2'b10: r = s;
            default: r = {31'd0, s[W-1] ^ v};
        endcase
        return {(c[1:0] == 2'b10) ? v : 1'b0, r == '0, r};
    endfunction

    assign {alu_overflow, alu_zero, alu_result} = alu_f(alu_src1, alu_src2,
        {alu_invert_a, alu_invert_b, alu_operation});

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]   v;
        logic [W-1:0] a0, b0, a1, b1;
        logic [3:0]   c0, c1;
        logic         id;
        logic [W-1:0] res;
        logic         z, o;
    } vec_t;

    // One full transaction; hold = cycles to keep resp_ready low in RESP.
    task automatic do_op(input vec_t t, input int hold);
        logic [W-1:0] a, b;
        logic [3:0] c;
        a = t.id ? t.a1 : t.a0;
        b = t.id ? t.b1 : t.b0;
        c = t.id ? t.c1 : t.c0;
        req_valid = t.v;
        req_src1 = {t.a1, t.a0};
        req_src2 = {t.b1, t.b0};
        req_ctrl = {t.c1, t.c0};
        #1;
        chk("req_ready", {30'd0, req_ready}, t.id ? 32'd2 : 32'd1);
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        chk("exec_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("exec_alu_src1", alu_src1, a);
        chk("exec_alu_ctrl", {28'd0, alu_invert_a, alu_invert_b, alu_operation}, {28'd0, c});
        @(negedge clk);
        chk("resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("resp_id", {31'd0, resp_id}, {31'd0, t.id});
        chk("resp_result", resp_result, t.res);
        chk("resp_flags", {30'd0, resp_zero, resp_overflow}, {30'd0, t.z, t.o});
        chk("resp_alu_idle", alu_src1 | alu_src2, 32'd0);
        if (hold > 0) req_valid = 2'b11;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_result", resp_result, t.res);
            chk("hold_id", {31'd0, resp_id}, {31'd0, t.id});
            chk("hold_ready", {30'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        chk("resp_cleared", {31'd0, resp_valid}, 32'd0);
        pref = ~t.id;
    endtask

    vec_t tab[10];
    vec_t t;

    initial begin
        tab[0] = '{2'b01, 32'd5, 32'd3, 32'd0, 32'd0, 4'b0010, 4'b0010, 1'b0, 32'd8, 1'b0, 1'b0};
        tab[1] = '{2'b11, 32'd10, 32'd4, 32'd20, 32'd5, 4'b0110, 4'b0110, 1'b1, 32'd15, 1'b0, 1'b0};
        tab[2] = '{2'b11, 32'd10, 32'd4, 32'd20, 32'd5, 4'b0110, 4'b0110, 1'b0, 32'd6, 1'b0, 1'b0};
        tab[3] = '{2'b11, 32'd10, 32'd4, 32'd20, 32'd5, 4'b0110, 4'b0110, 1'b1, 32'd15, 1'b0, 1'b0};
        tab[4] = '{2'b11, 32'd10, 32'd4, 32'd20, 32'd5, 4'b0110, 4'b0110, 1'b0, 32'd6, 1'b0, 1'b0};
        tab[5] = '{2'b10, 32'd0, 32'd0, 32'd7, 32'd7, 4'b0110, 4'b0110, 1'b1, 32'd0, 1'b1, 1'b0};
        tab[6] = '{2'b01, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, 4'b0010, 4'b0010, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tab[7] = '{2'b01, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 4'b0000, 4'b0000, 1'b0, 32'h00F0, 1'b0, 1'b0};
        tab[8] = '{2'b10, 32'd0, 32'd0, 32'hF000, 32'h000F, 4'b0001, 4'b0001, 1'b1, 32'hF00F, 1'b0, 1'b0};
        tab[9] = '{2'b01, 32'h80000000, 32'd1, 32'd0, 32'd0, 4'b0110, 4'b0110, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1};

        rst = 1'b1;
        req_valid = 2'b01;
        req_src1 = '0;
        req_src2 = '0;
        req_ctrl = '0;
        resp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_resp", {29'd0, resp_valid, resp_zero, resp_overflow} | resp_result, 32'd0);
        chk("rst_alu", alu_src1 | alu_src2 | {27'd0, alu_invert_a, alu_invert_b, alu_operation, resp_id}, 32'd0);
        req_valid = 2'b00;
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) do_op(tab[i], 0);

        // Response back-pressure: data held stable, no new grants.
        do_op('{2'b11, 32'd9, 32'd9, 32'd1, 32'd2, 4'b0010, 4'b0010, 1'b1, 32'd3, 1'b0, 1'b0}, 5);

        // Reset during EXEC after granting requester 0 (pointer would move to 1).
        req_valid = 2'b01;
        req_src1 = {32'd0, 32'd1};
        req_src2 = {32'd0, 32'd1};
        req_ctrl = 8'h22;
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_alu_cleared", alu_src1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        pref = 1'b0;
        do_op('{2'b11, 32'd4, 32'd4, 32'd1, 32'd1, 4'b0010, 4'b0010, 1'b0, 32'd8, 1'b0, 1'b0}, 0);

        // Random ops against the model: grant prefers the requester not served last.
        for (int n = 0; n < 150; n++) begin
            logic [3:0] c0, c1;
            logic [W+1:0] m;
            c0 = 4'($urandom_range(0, 15));
            c1 = 4'($urandom_range(0, 15));
            t.v  = 2'($urandom_range(1, 3));
            t.a0 = $urandom;
            t.b0 = ($urandom_range(0, 3) == 0) ? t.a0 : $urandom;
            t.a1 = $urandom;
            t.b1 = $urandom;
            t.c0 = c0;
            t.c1 = c1;
            t.id = (t.v == 2'b11) ? pref : t.v[1];
            m = t.id ? alu_f(t.a1, t.b1, c1) : alu_f(t.a0, t.b0, c0);
            t.res = m[W-1:0];
            t.z = m[W];
            t.o = m[W+1];
            do_op(t, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
